// File: rtl/audio_pkg.sv
// Shared constants for the audio sample path.
package audio_pkg;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned FIFO_ADDR_W = 13;
endpackage

// File: rtl/sdpb_fifo_sdp_ram.sv
// Behavioural simple dual-port RAM with a registered, enabled read port; infers block RAM.
module sdp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds its word until the next enabled read.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sdpb_fifo.sv
// FWFT FIFO over an inferred SDP block RAM with level, threshold flags, sticky errors and flush.
module sdpb_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W    = SAMPLE_W,
  parameter int unsigned ADDR_W    = FIFO_ADDR_W,
  parameter int unsigned AFULL_TH  = (2**ADDR_W) - 16,
  parameter int unsigned AEMPTY_TH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] DEPTH_LV  = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d, unread;
  logic              rd_pend_q, rd_pend_d, valid_q, valid_d;
  logic [DATA_W-1:0] dout_q, dout_d, ram_rdata;
  logic              full_q, full_d, afull_q, afull_d, aempty_q, aempty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              wr_acc, pop, load, ram_we, ram_re;

  always_comb begin
    wr_acc    = wr_en & ~full_q;
    pop       = rd_en & valid_q;
    // RAM read register acts as a one-word skid slot ahead of the output register.
    load      = rd_pend_q & (~valid_q | pop);
    unread    = level_q - (ADDR_W+1)'(rd_pend_q) - (ADDR_W+1)'(valid_q);
    ram_re    = (unread != '0) & (~rd_pend_q | load);
    ram_we    = wr_acc;

    wptr_d    = wptr_q + ADDR_W'(wr_acc);
    rptr_d    = rptr_q + ADDR_W'(ram_re);
    level_d   = level_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(pop);
    rd_pend_d = ram_re | (rd_pend_q & ~load);
    valid_d   = load | (valid_q & ~pop);
    dout_d    = load ? ram_rdata : dout_q;
    ovf_d     = ovf_q | (wr_en & full_q);
    udf_d     = udf_q | (rd_en & ~valid_q);

    if (clr) begin
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      wptr_d    = '0;
      rptr_d    = '0;
      level_d   = '0;
      rd_pend_d = 1'b0;
      valid_d   = 1'b0;
      dout_d    = dout_q;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end

    full_d   = (level_d == DEPTH_LV);
    afull_d  = (level_d >= AFULL_LV);
    aempty_d = (level_d <= AEMPTY_LV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      rd_pend_q <= rd_pend_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  sdp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wptr_q),
    .wdata_i (din),
    .re_i    (ram_re),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign valid        = valid_q;
  assign dout         = dout_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_sdpb_fifo.sv
// Directed self-checking bench for sdpb_fifo at DEPTH=16, AFULL_TH=14, AEMPTY_TH=2.
module tb_sdpb_fifo;
  logic        clk = 1'b0;
  logic        reset, clr, wr_en, rd_en;
  logic [15:0] din, dout;
  logic        full, almost_full, valid, almost_empty, overflow, underflow;
  logic [4:0]  level;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sdpb_fifo #(
    .DATA_W(16),
    .ADDR_W(4),
    .AFULL_TH(14),
    .AEMPTY_TH(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid        (valid),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    tick(); tick();
    check("rst_level", level, 0);
    check("rst_valid", valid, 0);
    check("rst_dout", dout, 0);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_aempty", almost_empty, 1);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    reset = 1'b0;
    tick();

    // Single write latency
    wr_en = 1'b1; din = 16'h1234;
    tick();
    wr_en = 1'b0;
    check("lat_level_n1", level, 1);
    check("lat_valid_n1", valid, 0);
    check("lat_aempty", almost_empty, 1);
    tick();
    check("lat_valid_n2pre", valid, 0);
    tick();
    check("lat_valid", valid, 1);
    check("lat_dout", dout, 16'h1234);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("lat_pop_level", level, 0);
    check("lat_pop_valid", valid, 0);

    // Fill to full, watch thresholds
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 16'(i);
      tick();
      check("fill_level", level, 32'(i + 1));
      check("fill_afull", almost_full, (i + 1 >= 14) ? 1 : 0);
      check("fill_aempty", almost_empty, (i + 1 <= 2) ? 1 : 0);
    end
    check("fill_full", full, 1);
    check("fill_ovf0", overflow, 0);
    din = 16'hAAAA;
    tick();
    wr_en = 1'b0;
    check("drop_ovf", overflow, 1);
    check("drop_level", level, 16);

    // Drain: back-to-back pops, no gaps
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", valid, 1);
      check("drain_dout", dout, 32'(i));
      tick();
    end
    rd_en = 1'b0;
    check("drain_valid_end", valid, 0);
    check("drain_level_end", level, 0);
    check("drain_full", full, 0);
    check("drain_udf0", underflow, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("udf_set", underflow, 1);
    check("udf_level", level, 0);

    // Steady state: 8 stored, 40 cycles of simultaneous write/pop across pointer wraps
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; din = 16'(100 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    for (int j = 0; j < 40; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 16'(108 + j);
      check("stream_valid", valid, 1);
      check("stream_dout", dout, 32'(100 + j));
      tick();
      check("stream_level", level, 8);
    end
    wr_en = 1'b0;
    for (int j = 40; j < 48; j++) begin
      check("stream_tail", dout, 32'(100 + j));
      tick();
    end
    rd_en = 1'b0;
    check("stream_empty", valid, 0);

    // Flush clears sticky flags
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_udf", underflow, 0);

    // Full with simultaneous write and pop
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 16'(200 + i);
      tick();
    end
    wr_en = 1'b0;
    tick(); tick();
    check("full2_full", full, 1);
    check("full2_dout", dout, 200);
    wr_en = 1'b1; rd_en = 1'b1; din = 16'hDEAD;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("full2_ovf", overflow, 1);
    check("full2_level", level, 15);
    check("full2_dout_next", dout, 201);
    check("full2_notfull", full, 0);

    // Pop down to 10 then flush
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rd_en = 1'b0;
    check("pre_clr_level", level, 10);
    check("pre_clr_dout", dout, 206);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_level", level, 0);
    check("clr_valid", valid, 0);
    check("clr_ovf2", overflow, 0);
    check("clr_aempty", almost_empty, 1);
    check("clr_afull", almost_full, 0);
    check("clr_dout_kept", dout, 206);
    wr_en = 1'b1; din = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    tick();
    check("clr_wr_valid_early", valid, 0);
    tick();
    check("clr_wr_valid", valid, 1);
    check("clr_wr_dout", dout, 16'hBEEF);
    check("clr_wr_level", level, 1);

    // Async reset in the middle of a burst
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; din = 16'(300 + i);
      tick();
    end
    rd_en = 1'b1;
    wr_en = 1'b1; din = 16'h7777;
    #2;
    reset = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", valid, 0);
    check("arst_dout", dout, 0);
    check("arst_full", full, 0);
    check("arst_aempty", almost_empty, 1);
    check("arst_ovf", overflow, 0);
    check("arst_udf", underflow, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    wr_en = 1'b1; din = 16'h55AA;
    tick();
    wr_en = 1'b0;
    tick(); tick();
    check("post_rst_valid", valid, 1);
    check("post_rst_dout", dout, 16'h55AA);
    check("post_rst_level", level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
